// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns 2-byte frames into register-bus read/write requests.
// Optional multi-byte auto-increment bursts are enabled with `define SPI_SLAVE_BURST_EN.
module spi_slave_regif #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MISO_IDLE   = 1'b0
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       frame_done,
  output logic       frame_err
);

`ifdef SPI_SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, RD_FETCH, DATA, WAIT_CS} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_prev, cs_prev;
  logic sclk_s, cs_s, mosi_s;
  logic rise_ev, fall_ev, cs_rise, cs_fall;

  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [6:0] tx_sr;
  logic       rw_q;
  logic       data_seen;

  logic byte_end, addr_ld, rd_fire, wr_fire, done_fire, abort_fire, addr_inc;
  logic shift_en, tx_load, tx_shift, cnt_en;

  // cs_n sync resets high so leaving reset never looks like a frame start.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise_ev = sclk_s & ~sclk_prev;
  assign fall_ev = ~sclk_s & sclk_prev;
  assign cs_rise = cs_s & ~cs_prev;
  assign cs_fall = ~cs_s & cs_prev;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (cs_fall) next_state = ADDR;
      ADDR: begin
        if (cs_rise)       next_state = IDLE;
        else if (byte_end) next_state = rx_sr[6] ? RD_FETCH : DATA;
      end
      RD_FETCH: next_state = cs_rise ? IDLE : DATA;
      DATA: begin
        if (cs_rise)       next_state = IDLE;
        else if (byte_end) next_state = BURST ? (rw_q ? RD_FETCH : DATA) : WAIT_CS;
      end
      WAIT_CS:  if (cs_rise) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // A cs_n rise on the same cycle as the 8th sclk rise aborts the byte.
  always_comb begin
    byte_end   = rise_ev && (bit_cnt == 3'd7) && !cs_rise;
    addr_ld    = (state == ADDR) && byte_end;
    done_fire  = (state == DATA) && byte_end;
    wr_fire    = done_fire && !rw_q;
    rd_fire    = (addr_ld && rx_sr[6]) || (BURST && done_fire && rw_q);
    addr_inc   = BURST && done_fire && (rw_q || data_seen);
    abort_fire = cs_rise && ((state == ADDR) ||
                             ((state == RD_FETCH) && !(BURST && data_seen)) ||
                             ((state == DATA) && !(BURST && data_seen && bit_cnt == 3'd0)));
    cnt_en     = (state == ADDR) || (state == DATA);
    shift_en   = cnt_en && rise_ev && !cs_rise;
    tx_load    = (state == RD_FETCH) && !cs_rise;
    // The fall closing the previous byte arrives with bit_cnt==0 and must not
    // disturb the MSB already presented by the fetch cycle.
    tx_shift   = (state == DATA) && rw_q && fall_ev && (bit_cnt != 3'd0) && !cs_rise;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      rw_q       <= 1'b0;
      data_seen  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      spi_miso   <= MISO_IDLE;
    end else begin
      reg_wr     <= wr_fire;
      reg_rd     <= rd_fire;
      frame_done <= done_fire;
      frame_err  <= abort_fire;

      if (shift_en)               bit_cnt <= bit_cnt + 3'd1;
      else if (!cnt_en || cs_rise) bit_cnt <= '0;

      if (shift_en) rx_sr <= {rx_sr[5:0], mosi_s};

      if (addr_ld) begin
        reg_addr <= {rx_sr[5:0], mosi_s};
        rw_q     <= rx_sr[6];
      end else if (addr_inc) begin
        reg_addr <= reg_addr + 7'd1;
      end

      if (wr_fire) reg_wdata <= {rx_sr, mosi_s};

      if (state == IDLE || addr_ld) data_seen <= 1'b0;
      else if (done_fire)           data_seen <= 1'b1;

      if (tx_load) begin
        spi_miso <= reg_rdata[7];
        tx_sr    <= reg_rdata[6:0];
      end else if (tx_shift) begin
        spi_miso <= tx_sr[6];
        tx_sr    <= {tx_sr[5:0], 1'b0};
      end else if (next_state != DATA) begin
        spi_miso <= MISO_IDLE;
      end
    end
  end

endmodule
